// File: rtl/cpu_program_memory.sv
// ============================================================================
// Module   : cpu_program_memory
// Purpose  : Instruction/data memories for the 16-bit core plus byte-stream boot loader
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_program_memory #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  input  logic              stop,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_datain,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_dataout,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_datain,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic              load_err
);

  localparam int          c_DEPTH     = 1 << ADDR_W;
  localparam logic [7:0]  c_HDR_IMEM  = 8'h00;
  localparam logic [7:0]  c_HDR_DMEM  = 8'h80;
  localparam logic [7:0]  c_HDR_GO    = 8'hFF;

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_BASE = 3'd1,
    S_CNT  = 3'd2,
    S_HI   = 3'd3,
    S_LO   = 3'd4,
    S_GO   = 3'd5,
    S_RUN  = 3'd6
  } state_t;

  logic [DATA_W-1:0] r_imem [c_DEPTH];
  logic [DATA_W-1:0] r_dmem [c_DEPTH];

  state_t            r_state;
  state_t            w_next;
  logic              r_live;
  logic              r_target_dmem;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_count;
  logic [7:0]        r_hi;
  logic              r_err;

  logic              w_loader_state;
  logic              w_accept;
  logic              w_err_set;
  logic              w_word_done;
  logic              w_core_we;
  logic [DATA_W-1:0] w_word;

  assign w_loader_state = (r_state == S_HDR) || (r_state == S_BASE) || (r_state == S_CNT) ||
                          (r_state == S_HI)  || (r_state == S_LO);
  // r_live holds ld_ready low until the first edge after reset release
  assign ld_ready    = r_live && !stop && w_loader_state;
  assign w_accept    = ld_valid && ld_ready;
  assign w_word_done = w_accept && (r_state == S_LO);
  assign w_word      = DATA_W'({r_hi, ld_byte});
  assign w_core_we   = d_we && ((r_state == S_GO) || (r_state == S_RUN));

  assign cpu_enable  = (r_state == S_GO) || (r_state == S_RUN);
  assign cpu_start   = (r_state == S_GO);
  assign load_err    = r_err;

  assign i_datain    = r_imem[i_addr];
  assign d_datain    = r_dmem[d_addr];

  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    case (r_state)
      S_HDR: begin
        if (w_accept) begin
          case (ld_byte)
            c_HDR_IMEM, c_HDR_DMEM: w_next = S_BASE;
            c_HDR_GO:               w_next = S_GO;
            default:                w_err_set = 1'b1;
          endcase
        end
      end
      S_BASE:  if (w_accept) w_next = S_CNT;
      S_CNT:   if (w_accept) w_next = S_HI;
      S_HI:    if (w_accept) w_next = S_LO;
      S_LO:    if (w_accept) w_next = (r_count == ADDR_W'(1)) ? S_HDR : S_HI;
      S_GO:    w_next = S_RUN;
      S_RUN:   w_next = S_RUN;
      default: w_next = S_HDR;
    endcase
    if (stop) w_next = S_HDR;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_HDR;
      r_live        <= 1'b0;
      r_target_dmem <= 1'b0;
      r_addr        <= '0;
      r_count       <= '0;
      r_hi          <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
      if (w_err_set) r_err <= 1'b1;
      if (w_accept) begin
        case (r_state)
          S_HDR:  r_target_dmem <= (ld_byte == c_HDR_DMEM);
          S_BASE: r_addr        <= ld_byte[ADDR_W-1:0];
          S_CNT:  r_count       <= ld_byte[ADDR_W-1:0];
          S_HI:   r_hi          <= ld_byte;
          S_LO: begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_count <= r_count - ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Storage is deliberately outside the reset domain so a reset keeps loaded words
  always_ff @(posedge clock) begin
    if (w_word_done && !r_target_dmem) r_imem[r_addr] <= w_word;
    if (w_word_done && r_target_dmem)  r_dmem[r_addr] <= w_word;
    else if (w_core_we)                r_dmem[d_addr] <= d_dataout;
  end

endmodule

`default_nettype wire
